cache_flush_reader: RTL

Flush sweep engine for the backend system cache. On a start pulse it walks every set and way of the system cache and issues one line-sized read per slot to an aliased address. Each read evicts, and so writes back, whatever the cache holds in that slot. The block consumes the matching read responses and raises done once every read has been answered. It sits between the kernel control path and a read port of the memory/cache fabric, and is the consumer of the flush address sweep defined for the system cache.

---
 rtl/cache_flush_reader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cache_flush_reader.sv
// cache_flush_reader: walks every set/way of the system cache issuing aliased line reads to force write-back.
// Optional CACHE_FLUSH_CYCLE_COUNTER_EN adds cycles_out, a saturating count of busy cycles.
module cache_flush_reader #(
    parameter int NUM_WAYS        = 4,
    parameter int LINE_SIZE_LOG   = 6,
    parameter int CACHE_SIZE      = 65536,
    parameter int ADDR_W          = 63,
    parameter int MAX_OUTSTANDING = 16,
    localparam int WAY_W    = $clog2(NUM_WAYS),
    localparam int NUM_SETS = CACHE_SIZE >> (LINE_SIZE_LOG + WAY_W),
    localparam int SET_W    = $clog2(NUM_SETS),
    localparam int COUNT    = NUM_SETS * NUM_WAYS,
    localparam int CNT_W    = $clog2(COUNT) + 1
) (
    input  logic              ap_clk,
    input  logic              areset,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] base_address_in,
    output logic              req_valid_out,
    input  logic              req_ready_in,
    output logic [ADDR_W-1:0] req_addr_out,
    input  logic              resp_valid_in,
    input  logic              resp_error_in,
    output logic              resp_ready_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              error_out,
    output logic [CNT_W-1:0]  issued_count_out
`ifdef CACHE_FLUSH_CYCLE_COUNTER_EN
    ,
    output logic [31:0]       cycles_out
`endif
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] base, base_n, addr_n;
    logic [CNT_W-1:0]  cnt_n;
    logic [OUT_W-1:0]  outstanding, out_n;
    logic              valid_n, err_n, done_n, req_fire, resp_take, start_ok;

    // Set-major walk: low counter bits pick the way (stride CACHE_SIZE/NUM_WAYS), high bits the set.
    function automatic logic [ADDR_W-1:0] flush_addr(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c);
        logic [ADDR_W-1:0] cw;
        cw = ADDR_W'(c);
        return b + ((cw >> WAY_W) << LINE_SIZE_LOG) + ((cw & ADDR_W'(NUM_WAYS - 1)) << (LINE_SIZE_LOG + SET_W));
    endfunction

    assign busy_out       = state == ISSUE || state == DRAIN;
    assign resp_ready_out = busy_out;
    assign req_fire       = req_valid_out && req_ready_in;
    assign resp_take      = resp_valid_in && resp_ready_out;
    assign start_ok       = start_in && (state == IDLE || state == DONE);

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state            <= IDLE;
            base             <= '0;
            issued_count_out <= '0;
            outstanding      <= '0;
            req_valid_out    <= 1'b0;
            req_addr_out     <= '0;
            error_out        <= 1'b0;
            done_out         <= 1'b0;
        end else begin
            state            <= state_n;
            base             <= base_n;
            issued_count_out <= cnt_n;
            outstanding      <= out_n;
            req_valid_out    <= valid_n;
            req_addr_out     <= addr_n;
            error_out        <= err_n;
            done_out         <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        base_n  = base;
        cnt_n   = issued_count_out;
        valid_n = req_valid_out;
        addr_n  = req_addr_out;
        done_n  = done_out;
        err_n   = error_out || (resp_take && resp_error_in);
        // A response alongside a request handshake nets to zero; a stray response never underflows.
        out_n   = (req_fire && !resp_take) ? outstanding + 1'b1 :
                  (!req_fire && resp_take && outstanding != '0) ? outstanding - 1'b1 : outstanding;
        case (state)
            IDLE, DONE: if (start_ok) begin
                state_n = ISSUE;
                base_n  = base_address_in;
                cnt_n   = '0;
                out_n   = '0;
                err_n   = 1'b0;
                done_n  = 1'b0;
                valid_n = 1'b1;
                addr_n  = base_address_in;
            end
            ISSUE: if (req_fire) begin
                cnt_n   = issued_count_out + 1'b1;
                addr_n  = flush_addr(base, issued_count_out + 1'b1);
                state_n = issued_count_out == CNT_W'(COUNT - 1) ? DRAIN : ISSUE;
                valid_n = issued_count_out != CNT_W'(COUNT - 1) && out_n < OUT_W'(MAX_OUTSTANDING);
            end else begin
                valid_n = out_n < OUT_W'(MAX_OUTSTANDING);
            end
            DRAIN: if (out_n == '0) begin
                state_n = DONE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef CACHE_FLUSH_CYCLE_COUNTER_EN
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset)
            cycles_out <= '0;
        else if (start_ok)
            cycles_out <= '0;
        else if (busy_out && cycles_out != '1)
            cycles_out <= cycles_out + 1'b1;
    end
`endif
endmodule
